pc_gen_multi: RTL and testbench
===============================

# pc_gen_multi

Parametrised fetch-PC generator for the front end, feeding the instruction cache and instruction buffer. It supports fetch groups of `FETCH_W` instructions and generates sequential PCs aligned to group boundaries. It follows predicted-taken branches whose delay slot falls in the next fetch group, using a two-state FSM with a saved target. It applies exception and misprediction redirects with fixed priority, and marks the valid slots of each fetch group.

## Interface

Parameters:
- `FETCH_W`, 2 — instructions per fetch group; legal values 1, 2, 4. Group size `GB = 4*FETCH_W` bytes.
- `RESET_PC`, 32'hbfc00000 — PC loaded by reset.
- `BPU_EN`, 1 — 0: all `bpu_*` inputs are ignored.

Ports (`SW = max(1, clog2(FETCH_W))`):
- `clk` in 1 — the single clock.
- `rst` in 1 — reset; synchronous, active-high.
- `flush` in 1 — redirect request from the back end.
- `flush_cause` in 1 — 1 = exception, 0 = failed branch prediction.
- `branch_flag` in 1 — the resolved branch was taken (used on a misprediction flush).
- `ex_pc` in 32 — PC of the mispredicted branch.
- `npc_actual` in 32 — resolved taken target.
- `epc` in 32 — exception handler / return target.
- `bpu_valid` in 1 — a taken prediction exists for the current group.
- `bpu_slot` in SW — absolute slot index (within the aligned group) of the predicted branch.
- `bpu_target` in 32 — predicted target.
- `ibuffer_full` in 1 — instruction buffer cannot accept.
- `stallreq_from_icache` in 1 — icache busy.
- `pc` out 32 — current fetch-group PC (registered).
- `rreq_to_icache` out 1 — fetch request for `pc` (combinational).
- `slot_mask` out FETCH_W — valid slots of the current group (combinational from `pc`).
- `ds_pending` out 1 — FSM is in WAIT_DS.

## Operation

- `stall = ibuffer_full | stallreq_from_icache`.
- A fetch is *issued* in a cycle where `rreq_to_icache` = 1.
- `rreq_to_icache = !rst & !flush & !stall`.
- Alignment base: `base = pc & ~(GB-1)`.
- Sequential next PC: `seq = base + GB`, with 32-bit wrap.
- `slot_mask` bit i = 1 iff `i >= pc[log2(GB)-1:2]`. For `FETCH_W=1` the mask is constant 1.
- FSM states:
  - RUN
  - WAIT_DS — delay slot is in the next group; the target is held in `ds_target`.
- Next-PC selection, highest priority first:
  1. `rst` → `RESET_PC`; state RUN.
  2. `flush & flush_cause` → `epc`; state RUN; `ds_target` is discarded.
  3. `flush & !flush_cause & branch_flag` → `npc_actual`; state RUN.
  4. `flush & !flush_cause & !branch_flag` → `ex_pc + 8`; state RUN.
  5. `stall` → hold `pc` and state.
  6. State WAIT_DS → `ds_target`; state RUN. `bpu_*` inputs are ignored in this state.
  7. `BPU_EN & bpu_valid`, slot < FETCH_W-1 → `bpu_target`. The delay slot is inside the current group.
  8. `BPU_EN & bpu_valid`, slot = FETCH_W-1 → `seq`; latch `ds_target <= bpu_target`; state WAIT_DS. With `FETCH_W=1`, every prediction takes this path.
  9. Otherwise → `seq`.
- A prediction whose `bpu_slot` is below the first valid slot is a BPU error. It is treated as no prediction (rule 9).

## Timing

- `pc` and state update on every `clk` rising edge. `pc` takes the selected next PC; there is no enable other than hold-on-stall.
- Redirect latency is one cycle: a flush asserted in cycle N produces `pc` = target in cycle N+1, which is fetched in N+1 if not stalled.
- Flush overrides stall: the PC still updates while `rreq_to_icache` = 0.
- BPU inputs are sampled only in cycles where a fetch is issued. A predicted redirect appears on `pc` the following cycle.
- WAIT_DS lasts exactly one issued fetch (the delay-slot group) plus any stall cycles.
- Reset mid-operation: the next edge loads `RESET_PC`, state RUN, and `ds_pending` = 0.
- Reset values:
  - `pc` = `RESET_PC`.
  - `ds_pending` = 0.
  - `ds_target` = 0.
  - `rreq_to_icache` = 0 while `rst` is high.
  - `slot_mask` = all-ones, since `RESET_PC` is aligned.

## Test plan

All scenarios use FETCH_W=2.

1. Reset, then run 3 unstalled cycles → `pc` = bfc00000, bfc00008, bfc00010; `slot_mask` = 2'b11; `rreq_to_icache` = 1 after reset.
2. Misprediction flush, taken, `npc_actual` = bfc00104 → next `pc` = bfc00104 with `slot_mask` = 2'b10, then bfc00108 with `slot_mask` = 2'b11. Misprediction flush, not-taken, `ex_pc` = 80000010 → next `pc` = 80000018.
3. At `pc` = 80001000, `bpu_valid`, slot 0, target 80002000 → next `pc` = 80002000. Same PC with slot 1 → 80001008 with `ds_pending` = 1, then 80002000 with `ds_pending` = 0.
4. WAIT_DS with `stallreq_from_icache` held 3 cycles → `pc` holds at 80001008, `rreq_to_icache` = 0, `ds_pending` = 1. Then an exception flush with `epc` = bfc00380 → `pc` = bfc00380, `ds_pending` = 0, saved target never used.
5. Same cycle: `flush` with `flush_cause` = 1, `ibuffer_full` = 1, `bpu_valid` = 1 → `pc` = `epc`, `rreq_to_icache` = 0. With `BPU_EN` = 0, `bpu_valid` = 1 has no effect on sequential stepping.
6. `pc` = fffffff8, no events → `pc` wraps to 00000000.

Source files
------------

// File: rtl/pc_gen_multi.sv
// Fetch-PC generator: group-aligned sequential PCs, predicted branches with delay-slot tracking, flush redirects.
// Latency: one cycle from a redirect or prediction to the new pc; rreq_to_icache and slot_mask are combinational.
// Backpressure: ibuffer_full or stallreq_from_icache holds pc and state; a flush still redirects during a stall.
module pc_gen_multi #(
  parameter int          FETCH_W  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter bit          BPU_EN   = 1'b1,
  localparam int         SW       = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               flush_cause,
  input  logic               branch_flag,
  input  logic [31:0]        ex_pc,
  input  logic [31:0]        npc_actual,
  input  logic [31:0]        epc,
  input  logic               bpu_valid,
  input  logic [SW-1:0]      bpu_slot,
  input  logic [31:0]        bpu_target,
  input  logic               ibuffer_full,
  input  logic               stallreq_from_icache,
  output logic [31:0]        pc,
  output logic               rreq_to_icache,
  output logic [FETCH_W-1:0] slot_mask,
  output logic               ds_pending
);

  localparam int GB   = 4 * FETCH_W;
  localparam int OFFW = $clog2(GB);

  typedef enum logic {RUN = 1'b0, WAIT_DS = 1'b1} state_t;

  state_t      state;
  logic [31:0] ds_target;
  logic [31:0] base;
  logic [31:0] seq;
  logic [SW-1:0] cur_slot;
  logic        stall;
  logic        bpu_hit;
  logic        bpu_last;

  assign stall          = ibuffer_full | stallreq_from_icache;
  assign rreq_to_icache = !rst && !flush && !stall;
  assign base           = pc & ~(32'(GB) - 32'd1);
  assign seq            = base + 32'(GB);
  assign ds_pending     = (state == WAIT_DS);

  // Slot of the first valid instruction in the current group; a single-slot group always starts at 0.
  generate
    if (FETCH_W > 1) begin : g_slot
      assign cur_slot = pc[OFFW-1:2];
    end else begin : g_slot1
      assign cur_slot = '0;
    end
  endgenerate

  // Slots at or after the entry point of the group are valid.
  generate
    for (genvar i = 0; i < FETCH_W; i++) begin : g_mask
      assign slot_mask[i] = (i >= int'(cur_slot));
    end
  endgenerate

  // A prediction pointing before the entry slot is bogus and is dropped.
  assign bpu_hit  = BPU_EN && bpu_valid && (bpu_slot >= cur_slot);
  assign bpu_last = (FETCH_W == 1) || (bpu_slot == SW'(FETCH_W - 1));

  // Next-PC selection in fixed priority order; the FSM state and saved target live here too.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= RUN;
      ds_target <= '0;
    end else if (flush && flush_cause) begin
      pc        <= epc;
      state     <= RUN;
      ds_target <= '0;
    end else if (flush && branch_flag) begin
      pc    <= npc_actual;
      state <= RUN;
    end else if (flush) begin
      pc    <= ex_pc + 32'd8;
      state <= RUN;
    end else if (stall) begin
      // hold pc, state and saved target
    end else if (state == WAIT_DS) begin
      pc    <= ds_target;
      state <= RUN;
    end else if (bpu_hit && !bpu_last) begin
      pc <= bpu_target;
    end else if (bpu_hit) begin
      pc        <= seq;
      ds_target <= bpu_target;
      state     <= WAIT_DS;
    end else begin
      pc <= seq;
    end
  end

endmodule

// File: tb/tb_pc_gen_multi.sv
module tb_pc_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, flush_cause, branch_flag;
  logic [31:0] ex_pc, npc_actual, epc;
  logic        bpu_valid;
  logic [0:0]  bpu_slot;
  logic [31:0] bpu_target;
  logic        ibuffer_full, stallreq_from_icache;

  logic [31:0] pc0, pc1;
  logic        rreq0, rreq1;
  logic [1:0]  mask0, mask1;
  logic        ds0, ds1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          unit;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        ds;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_gen_multi #(.FETCH_W(2), .RESET_PC(32'hbfc00000), .BPU_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause), .branch_flag(branch_flag),
    .ex_pc(ex_pc), .npc_actual(npc_actual), .epc(epc), .bpu_valid(bpu_valid), .bpu_slot(bpu_slot),
    .bpu_target(bpu_target), .ibuffer_full(ibuffer_full), .stallreq_from_icache(stallreq_from_icache),
    .pc(pc0), .rreq_to_icache(rreq0), .slot_mask(mask0), .ds_pending(ds0));

  pc_gen_multi #(.FETCH_W(2), .RESET_PC(32'hbfc00000), .BPU_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause), .branch_flag(branch_flag),
    .ex_pc(ex_pc), .npc_actual(npc_actual), .epc(epc), .bpu_valid(bpu_valid), .bpu_slot(bpu_slot),
    .bpu_target(bpu_target), .ibuffer_full(ibuffer_full), .stallreq_from_icache(stallreq_from_icache),
    .pc(pc1), .rreq_to_icache(rreq1), .slot_mask(mask1), .ds_pending(ds1));

  task automatic push(input string tag, input int unit, input logic [31:0] p,
                      input logic [1:0] m, input logic d);
    exp_t e;
    e.tag = tag; e.unit = unit; e.pc = p; e.mask = m; e.ds = d;
    q.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against the registered outputs.
  task automatic tick();
    exp_t e;
    logic [31:0] op;
    logic [1:0]  om;
    logic        od;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e  = q.pop_front();
      op = (e.unit == 0) ? pc0 : pc1;
      om = (e.unit == 0) ? mask0 : mask1;
      od = (e.unit == 0) ? ds0 : ds1;
      checks++;
      assert (op === e.pc) else begin
        errors++;
        $error("FAIL %s pc: got %h want %h", e.tag, op, e.pc);
      end
      checks++;
      assert (om === e.mask) else begin
        errors++;
        $error("FAIL %s slot_mask: got %b want %b", e.tag, om, e.mask);
      end
      checks++;
      assert (od === e.ds) else begin
        errors++;
        $error("FAIL %s ds_pending: got %b want %b", e.tag, od, e.ds);
      end
    end
  endtask

  task automatic chk_rreq(input string tag, input logic want);
    #1;
    checks++;
    assert (rreq0 === want) else begin
      errors++;
      $error("FAIL %s rreq: got %b want %b", tag, rreq0, want);
    end
  endtask

  task automatic idle();
    flush = 0; flush_cause = 0; branch_flag = 0;
    bpu_valid = 0; bpu_slot = '0; bpu_target = '0;
    ibuffer_full = 0; stallreq_from_icache = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    flush = 1; flush_cause = 0; branch_flag = 1; npc_actual = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; ex_pc = '0; npc_actual = '0; epc = '0;
    idle();
    // 1: reset and sequential stepping
    push("reset", 0, 32'hbfc00000, 2'b11, 1'b0);
    tick();
    chk_rreq("rreq_in_reset", 1'b0);
    rst = 0;
    chk_rreq("rreq_after_reset", 1'b1);
    push("seq1", 0, 32'hbfc00008, 2'b11, 1'b0); tick();
    push("seq2", 0, 32'hbfc00010, 2'b11, 1'b0); tick();

    // 2: misprediction flushes
    redirect(32'hbfc00104);
    chk_rreq("rreq_flush", 1'b0);
    push("mis_taken", 0, 32'hbfc00104, 2'b10, 1'b0); tick();
    idle();
    push("after_mis", 0, 32'hbfc00108, 2'b11, 1'b0); tick();
    flush = 1; branch_flag = 0; ex_pc = 32'h80000010;
    push("mis_nt", 0, 32'h80000018, 2'b11, 1'b0); tick();

    // 3: predictions inside and at the end of the group
    idle(); redirect(32'h80001000);
    push("to_1000", 0, 32'h80001000, 2'b11, 1'b0); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b0; bpu_target = 32'h80002000;
    push("bpu_s0", 0, 32'h80002000, 2'b11, 1'b0); tick();
    idle(); redirect(32'h80001000); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b1; bpu_target = 32'h80002000;
    push("bpu_s1", 0, 32'h80001008, 2'b11, 1'b1); tick();
    bpu_slot = 1'b0; bpu_target = 32'h80003000;
    push("ds_taken", 0, 32'h80002000, 2'b11, 1'b0); tick();

    // BPU error: slot below first valid slot is ignored
    idle(); redirect(32'h80001004);
    push("to_1004", 0, 32'h80001004, 2'b10, 1'b0); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b0; bpu_target = 32'h80005000;
    push("bpu_err", 0, 32'h80001008, 2'b11, 1'b0); tick();

    // 4: stall during WAIT_DS, then exception discards the saved target
    idle(); redirect(32'h80001000); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b1; bpu_target = 32'h80002000;
    push("ds_enter", 0, 32'h80001008, 2'b11, 1'b1); tick();
    idle(); stallreq_from_icache = 1;
    for (int i = 0; i < 3; i++) begin
      chk_rreq("rreq_stall", 1'b0);
      push("ds_stall", 0, 32'h80001008, 2'b11, 1'b1); tick();
    end
    flush = 1; flush_cause = 1; epc = 32'hbfc00380;
    push("exc_in_ds", 0, 32'hbfc00380, 2'b11, 1'b0); tick();
    idle();
    push("no_ds_tgt", 0, 32'hbfc00388, 2'b11, 1'b0); tick();

    // 5: exception beats stall and prediction; BPU_EN=0 instance ignores predictions
    flush = 1; flush_cause = 1; epc = 32'hbfc00380; ibuffer_full = 1; bpu_valid = 1;
    chk_rreq("rreq_exc_stall", 1'b0);
    push("exc_prio", 0, 32'hbfc00380, 2'b11, 1'b0);
    push("exc_prio_u1", 1, 32'hbfc00380, 2'b11, 1'b0); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b0; bpu_target = 32'h80002000;
    push("bpu_on", 0, 32'h80002000, 2'b11, 1'b0);
    push("bpu_off", 1, 32'hbfc00388, 2'b11, 1'b0); tick();

    // 6: 32-bit wrap
    idle(); redirect(32'hfffffff8);
    push("to_fff8", 0, 32'hfffffff8, 2'b11, 1'b0); tick();
    idle();
    push("wrap", 0, 32'h00000000, 2'b11, 1'b0); tick();

    // reset while a delay slot is pending
    redirect(32'h80001000); tick();
    idle(); bpu_valid = 1; bpu_slot = 1'b1; bpu_target = 32'h80002000;
    push("ds_again", 0, 32'h80001008, 2'b11, 1'b1); tick();
    idle(); rst = 1;
    push("rst_mid", 0, 32'hbfc00000, 2'b11, 1'b0); tick();
    rst = 0;
    push("rst_seq", 0, 32'hbfc00008, 2'b11, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
